// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between an instruction-fetch port and a data-memory port.
// One access is in flight at a time; fetches are protected from starvation by a DM grant streak limit.
module mem_arbiter #(
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [63:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [63:0] dm_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            owner_dm_r;
    logic            we_r;
    logic [63:0]     addr_r;
    logic [63:0]     wdata_r;
    logic [2:0]      cnt_r;
    logic            first_r;
    logic [SW-1:0]   streak_r;
    logic [63:0]     if_rdata_r;
    logic [63:0]     dm_rdata_r;
    logic            grant_dm_s;
    logic            grant_if_s;
    logic            last_acc_s;

    // Next-state and arbitration decision
    always_comb begin
        state_nxt_s = state_r;
        grant_dm_s  = 1'b0;
        grant_if_s  = 1'b0;
        last_acc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // DM wins ties until it has starved a waiting fetch STARVE times in a row
                if (dm_req && !(if_req && (streak_r == SW'(STARVE)))) begin
                    grant_dm_s  = 1'b1;
                    state_nxt_s = ACC;
                end else if (if_req) begin
                    grant_if_s  = 1'b1;
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC: begin
                if (we_r || (cnt_r == 3'd1)) begin
                    last_acc_s  = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Access latch, latency counter, streak and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_dm_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 64'd0;
            wdata_r    <= 64'd0;
            cnt_r      <= 3'd0;
            first_r    <= 1'b0;
            streak_r   <= '0;
            if_rdata_r <= 64'd0;
            dm_rdata_r <= 64'd0;
        end else begin
            first_r <= grant_dm_s | grant_if_s;
            if (grant_dm_s) begin
                owner_dm_r <= 1'b1;
                we_r       <= dm_we;
                addr_r     <= dm_addr;
                wdata_r    <= dm_wdata;
                cnt_r      <= 3'(LAT);
                if (if_req && (streak_r != SW'(STARVE))) begin
                    streak_r <= streak_r + SW'(1);
                end
            end else if (grant_if_s) begin
                owner_dm_r <= 1'b0;
                we_r       <= 1'b0;
                addr_r     <= if_addr;
                wdata_r    <= 64'd0;
                cnt_r      <= 3'(LAT);
                streak_r   <= '0;
            end else if (state_r == ACC) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if ((state_r == ACC) && last_acc_s && !we_r) begin
                if (owner_dm_r) begin
                    dm_rdata_r <= mem_rdata;
                end else begin
                    if_rdata_r <= mem_rdata;
                end
            end
        end
    end

    // Outputs decode registered state only
    assign if_gnt    = (state_r == ACC) && first_r && !owner_dm_r;
    assign dm_gnt    = (state_r == ACC) && first_r && owner_dm_r;
    assign if_done   = (state_r == DONE) && !owner_dm_r;
    assign dm_done   = (state_r == DONE) && owner_dm_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_addr  = (state_r == ACC) ? addr_r : 64'd0;
    assign mem_wdata = (state_r == ACC) ? wdata_r : 64'd0;
    assign mem_wr    = (state_r == ACC) && we_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants push expected done data/timing, done pulses pop and compare.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [63:0] if_addr = 64'd0, dm_addr = 64'd0, dm_wdata = 64'd0;
    logic        if_gnt, if_done, dm_gnt, dm_done, mem_wr, busy;
    logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_dm_req = 1'b0;
    logic [63:0] b_dm_addr = 64'd0;
    logic        b_if_gnt, b_if_done, b_dm_gnt, b_dm_done, b_mem_wr, b_busy;
    logic [63:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h40) return 64'h0000_0000_0050_0093;
        return (a ^ 64'hA5A5_0000_0000_5A5A) + 64'd7;
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_arbiter #(.LAT(LAT), .STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_arbiter #(.LAT(1), .STARVE(4)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(64'd0), .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(1'b0), .dm_addr(b_dm_addr), .dm_wdata(64'd0),
        .dm_gnt(b_dm_gnt), .dm_done(b_dm_done), .dm_rdata(b_dm_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dm_q[$];
    bit          order_q[$];
    bit          rec = 1'b0;
    logic [63:0] exp_dm_last = 64'd0;
    int          cyc = 0;
    int          last_done = -10;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: push on grant, pop and compare on done
    always @(negedge clk) begin
        exp_t e;
        if (if_gnt || dm_gnt) begin
            check("gnt_excl", {63'd0, if_gnt & dm_gnt}, 64'd0);
            check("idle_gap", {63'd0, (cyc - last_done) >= 2}, 64'd1);
        end
        if (if_gnt) begin
            e.data = mem_model(if_addr);
            e.cyc  = cyc + LAT;
            if_q.push_back(e);
            if (rec) order_q.push_back(1'b0);
        end
        if (dm_gnt) begin
            e.data = dm_we ? exp_dm_last : mem_model(dm_addr);
            e.cyc  = cyc + (dm_we ? 1 : LAT);
            dm_q.push_back(e);
            if (!dm_we) exp_dm_last = mem_model(dm_addr);
            if (rec) order_q.push_back(1'b1);
        end
        if (if_done || dm_done) begin
            check("done_excl", {63'd0, if_done & dm_done}, 64'd0);
            last_done = cyc;
        end
        if (if_done) begin
            if (if_q.size() == 0) begin
                check("if_done_unexpected", 64'd1, 64'd0);
            end else begin
                e = if_q.pop_front();
                check("if_done_cyc", 64'(cyc), 64'(e.cyc));
                check("if_rdata", if_rdata, e.data);
            end
        end
        if (dm_done) begin
            if (dm_q.size() == 0) begin
                check("dm_done_unexpected", 64'd1, 64'd0);
            end else begin
                e = dm_q.pop_front();
                check("dm_done_cyc", 64'(cyc), 64'(e.cyc));
                check("dm_rdata", dm_rdata, e.data);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {58'd0, busy, if_gnt, dm_gnt, if_done, dm_done, mem_wr}, 64'd0);
        check({tag, "_data"}, mem_addr | mem_wdata | if_rdata | dm_rdata, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("in_reset");
        reset = 1'b0;
        if_q.delete();
        dm_q.delete();
        exp_dm_last = 64'd0;
        @(negedge clk);
        check_quiet("post_reset");
    endtask

    task automatic access(input bit is_dm, input bit we, input logic [63:0] addr,
                          input logic [63:0] wd);
        int n;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_dm ? dm_gnt : if_gnt) && n < 20);
        check("gnt_latency", 64'(n), 64'd1);
        check("mem_addr", mem_addr, addr);
        check("mem_wr", {63'd0, mem_wr}, {63'd0, is_dm & we});
        if (is_dm && we) check("mem_wdata", mem_wdata, wd);
        if_req = 1'b0;
        dm_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_dm ? dm_done : if_done) && n < 20);
        check("done_latency", 64'(n), (is_dm && we) ? 64'd1 : 64'(LAT));
        check("mem_wr_off", {63'd0, mem_wr}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        do_reset();

        access(1'b0, 1'b0, 64'h40, 64'd0);
        check("if_rdata_fetch", if_rdata, 64'h0000_0000_0050_0093);
        access(1'b1, 1'b1, 64'h100, 64'hDEAD);
        check("dm_rdata_after_wr", dm_rdata, 64'd0);
        access(1'b1, 1'b0, 64'h140, 64'd0);
        access(1'b1, 1'b1, 64'h180, 64'h1234_5678_9ABC_DEF0);
        check("dm_rdata_hold", dm_rdata, mem_model(64'h140));
        access(1'b0, 1'b0, 64'h1000, 64'd0);
        check("if_rdata_new", if_rdata, mem_model(64'h1000));

        // Reset during the second ACC cycle of a read aborts it silently
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h600;
        @(negedge clk);
        check("abort_gnt", {63'd0, dm_gnt}, 64'd1);
        dm_req = 1'b0;
        @(negedge clk);
        check("abort_busy_acc", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dm_q.delete();
        exp_dm_last = 64'd0;
        check_quiet("abort");
        @(negedge clk);
        check_quiet("abort_after");

        // Both requesters held: DM four times, then IF, repeating
        do_reset();
        if_addr = 64'h300; dm_addr = 64'h200; dm_we = 1'b0;
        rec = 1'b1; if_req = 1'b1; dm_req = 1'b1;
        n = 0;
        while (order_q.size() < 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if_req = 1'b0; dm_req = 1'b0; rec = 1'b0;
        check("order_count", {63'd0, order_q.size() >= 10}, 64'd1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10 && i < order_q.size(); i++)
            check($sformatf("order_%0d", i), {63'd0, order_q[i]}, (i % 5 == 4) ? 64'd0 : 64'd1);

        // LAT=1 read with request dropped right after grant
        b_dm_req = 1'b1; b_dm_addr = 64'h80;
        @(negedge clk);
        check("lat1_gnt", {62'd0, b_dm_gnt, b_dm_done}, 64'd2);
        b_dm_req = 1'b0;
        @(negedge clk);
        check("lat1_done", {63'd0, b_dm_done}, 64'd1);
        check("lat1_rdata", b_dm_rdata, mem_model(64'h80));
        @(negedge clk);
        check("lat1_idle", {62'd0, b_busy, b_dm_done}, 64'd0);

        check("if_q_empty", 64'(if_q.size()), 64'd0);
        check("dm_q_empty", 64'(dm_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
